// File: rtl/accel_sample_buffer.sv
// Block-averages signed Y/Z accelerometer samples and queues the averaged pairs
// in a FIFO that firmware drains over a 4-register memory-bus slave.
module accel_sample_buffer #(
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned AVG_LOG2 = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sample_valid,
    input  logic [7:0]  accel_y,
    input  logic [7:0]  accel_z,
    input  logic        bus_valid,
    input  logic        bus_write,
    input  logic [1:0]  bus_addr,
    input  logic [31:0] bus_wdata,
    output logic [31:0] bus_rdata,
    output logic        bus_ready,
    output logic        irq,
    output logic [31:0] display_word
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned AW = 8 + AVG_LOG2;
    localparam int unsigned SW = (AVG_LOG2 == 0) ? 1 : AVG_LOG2;
    localparam logic [SW-1:0] LAST_SAMPLE = SW'((1 << AVG_LOG2) - 1);
    localparam logic [CW-1:0] FULL_COUNT  = CW'(DEPTH);

    typedef enum logic [1:0] {
        REG_DATA   = 2'd0,
        REG_STATUS = 2'd1,
        REG_CTRL   = 2'd2,
        REG_LATEST = 2'd3
    } reg_sel_t;

    logic                 enable;
    logic [7:0]           threshold;
    logic                 overflow;
    logic                 armed;
    logic                 latest_valid;
    logic [7:0]           latest_y;
    logic [7:0]           latest_z;
    logic [PW-1:0]        wr_ptr;
    logic [PW-1:0]        rd_ptr;
    logic [CW-1:0]        count;
    logic signed [AW-1:0] acc_y;
    logic signed [AW-1:0] acc_z;
    logic [SW-1:0]        scnt;
    logic [7:0]           mem_y [DEPTH];
    logic [7:0]           mem_z [DEPTH];

    reg_sel_t             sel;
    logic                 accept;
    logic                 is_read;
    logic                 ctrl_wr;
    logic                 flush;
    logic                 empty;
    logic                 full;
    logic                 pop;
    logic                 sample_fire;
    logic                 block_done;
    logic                 push;
    logic                 push_ok;
    logic signed [AW-1:0] sum_y;
    logic signed [AW-1:0] sum_z;
    logic signed [AW-1:0] avg_y_full;
    logic signed [AW-1:0] avg_z_full;
    logic [7:0]           avg_y;
    logic [7:0]           avg_z;
    logic [8:0]           count9;
    logic [31:0]          head_word;
    logic [31:0]          rd_value;
    logic                 unused_bits;

    assign sel         = reg_sel_t'(bus_addr);
    // armed holds off a request that was already high when reset released
    assign accept      = bus_valid && !bus_ready && armed;
    assign is_read     = accept && !bus_write;
    assign ctrl_wr     = accept && bus_write && (sel == REG_CTRL);
    assign flush       = ctrl_wr && bus_wdata[1];
    assign empty       = (count == '0);
    assign full        = (count == FULL_COUNT);
    assign pop         = is_read && (sel == REG_DATA) && !empty;
    assign sample_fire = enable && sample_valid;
    assign block_done  = sample_fire && (scnt == LAST_SAMPLE);
    assign push        = block_done && !flush;
    assign push_ok     = push && (!full || pop);

    assign sum_y      = acc_y + AW'($signed(accel_y));
    assign sum_z      = acc_z + AW'($signed(accel_z));
    assign avg_y_full = sum_y >>> AVG_LOG2;
    assign avg_z_full = sum_z >>> AVG_LOG2;
    assign avg_y      = avg_y_full[7:0];
    assign avg_z      = avg_z_full[7:0];

    always_comb begin
        count9          = '0;
        count9[CW-1:0]  = count;
    end

    assign head_word = empty ? '0 : {1'b1, 15'd0, mem_y[rd_ptr], mem_z[rd_ptr]};

    always_comb begin
        rd_value = '0;
        case (sel)
            REG_DATA:   rd_value = head_word;
            REG_STATUS: rd_value = {13'd0, overflow, full, empty, 7'd0, count9};
            REG_CTRL:   rd_value = {16'd0, threshold, 7'd0, enable};
            REG_LATEST: rd_value = {latest_valid, 15'd0, latest_y, latest_z};
            default:    rd_value = '0;
        endcase
    end

    assign irq          = enable && (threshold != 8'd0) && (count9 >= {1'b0, threshold});
    assign display_word = {8'h00, latest_y, 8'h00, latest_z};
    assign unused_bits  = ^{bus_wdata[31:16], bus_wdata[7:3], avg_y_full, avg_z_full};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            enable       <= 1'b0;
            threshold    <= '0;
            overflow     <= 1'b0;
            armed        <= 1'b0;
            latest_valid <= 1'b0;
            latest_y     <= '0;
            latest_z     <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            acc_y        <= '0;
            acc_z        <= '0;
            scnt         <= '0;
            bus_ready    <= 1'b0;
            bus_rdata    <= '0;
        end else begin
            armed     <= armed | ~bus_valid;
            bus_ready <= accept;
            bus_rdata <= is_read ? rd_value : '0;

            if (ctrl_wr) begin
                enable    <= bus_wdata[0];
                threshold <= bus_wdata[15:8];
                if (bus_wdata[2]) overflow <= 1'b0;
            end
            // a dropped entry wins over a same-cycle overflow clear
            if (push && !push_ok) overflow <= 1'b1;

            if (flush || !enable) begin
                acc_y <= '0;
                acc_z <= '0;
                scnt  <= '0;
            end else if (sample_fire) begin
                if (block_done) begin
                    acc_y <= '0;
                    acc_z <= '0;
                    scnt  <= '0;
                end else begin
                    acc_y <= sum_y;
                    acc_z <= sum_z;
                    scnt  <= scnt + 1'b1;
                end
            end

            if (flush) begin
                latest_valid <= 1'b0;
            end else if (push) begin
                latest_valid <= 1'b1;
                latest_y     <= avg_y;
                latest_z     <= avg_z;
            end

            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push_ok) wr_ptr <= wr_ptr + 1'b1;
                if (pop)     rd_ptr <= rd_ptr + 1'b1;
                if (push_ok && !pop)      count <= count + 1'b1;
                else if (!push_ok && pop) count <= count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_y[wr_ptr] <= avg_y;
            mem_z[wr_ptr] <= avg_z;
        end
    end

endmodule

// File: doc/accel_sample_buffer.md
# accel_sample_buffer

Sits between `accelerometer_reader` and the picorv32 memory bus in `system`. Averages signed 8-bit Y/Z accelerometer samples over a block of 2^AVG_LOG2 samples and buffers the averaged pairs in a FIFO, so firmware can read them in bursts instead of polling raw registers. It raises a level interrupt when the FIFO fill reaches a programmable threshold. It also drives the latest averaged pair to `seven_segment_hex`.

## Interface
- `DEPTH`, 16: FIFO entries, power of two, 2..256.
- `AVG_LOG2`, 2: log2 of samples averaged per entry, 0..4.
- `clk` in 1: system clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `sample_valid` in 1: one-cycle strobe; `accel_y`/`accel_z` valid with it.
- `accel_y` in 8: signed Y sample.
- `accel_z` in 8: signed Z sample.
- `bus_valid` in 1: bus request, held high until `bus_ready`.
- `bus_write` in 1: 1 = write, 0 = read.
- `bus_addr` in 2: word register select.
- `bus_wdata` in 32: write data.
- `bus_rdata` out 32: read data, valid while `bus_ready` = 1.
- `bus_ready` out 1: one-cycle completion pulse.
- `irq` out 1: level interrupt.
- `display_word` out 32: {8'h00, Y_avg, 8'h00, Z_avg} of the latest entry.

## Operation
- Registers:
  - 0 DATA (R): pops one entry. Returns {bit31 = 1, 15'b0, Y_avg[15:8], Z_avg[7:0]}. When the FIFO is empty it returns 0 and does not pop.
  - 1 STATUS (R): bits[8:0] = count, bit16 = empty, bit17 = full, bit18 = overflow (sticky).
  - 2 CTRL (R/W): bit0 = enable, bits[15:8] = threshold. On write, bit1 = flush and bit2 = clear overflow; both are self-clearing and read back as 0.
  - 3 LATEST (R): same format as DATA, no pop. Bit31 = 1 once any entry has been produced since reset or flush.
- Writes to DATA, STATUS and LATEST are ignored but still complete.
- Accumulation:
  - Y and Z accumulators are signed, 8+AVG_LOG2 bits, and a sample counter runs 0..2^AVG_LOG2−1.
  - When enable = 1, each `sample_valid` adds the sign-extended samples.
  - On the final sample of a block, average = (acc + sample) >>> AVG_LOG2, an arithmetic shift (floor toward −inf). The result, bits [7:0], is pushed, LATEST is updated, and the accumulators and counter clear.
  - When enable = 0, `sample_valid` is ignored and the accumulators and counter are held at 0.
- FIFO:
  - Write pointer, read pointer and a separate count of 0..DEPTH. Pointers wrap modulo DEPTH.
  - A push is accepted if count < DEPTH or a pop happens in the same cycle.
  - Otherwise the entry is dropped, overflow is set, and LATEST still updates.
  - Simultaneous push and pop: both take effect and count is unchanged.
- Flush clears the pointers, count, accumulators, sample counter and the LATEST valid bit. Overflow and CTRL fields are not affected. If flush coincides with a push, the flush wins and the entry is discarded.
- `irq` = enable && threshold != 0 && count >= threshold, computed from registered state.
- Reset sets all registers and outputs to 0: enable = 0, threshold = 0, count = 0, overflow = 0, `bus_ready` = 0, `bus_rdata` = 0, `irq` = 0, `display_word` = 0.

## Timing
- Bus handshake:
  - A request is accepted on an edge where `bus_valid` && !`bus_ready`.
  - `bus_ready` is 1 for exactly the next cycle, with `bus_rdata` registered. `bus_rdata` returns to 0 when `bus_ready` is 0.
  - The cycle in which `bus_valid` and `bus_ready` are both high is not a new request, so there is one access per two cycles at most.
- A pop or register write takes effect at the acceptance edge. The DATA read value is the FIFO head before that pop.
- Push latency: the entry is in the FIFO (count, STATUS, `display_word`, `irq`) on the edge at which the final `sample_valid` of the block is sampled. It is visible the following cycle.
- An enable written to 0 in the same cycle as `sample_valid`: the new enable value applies from the next edge, so that sample is still accumulated.
- Reset asserted mid-block or mid-handshake: all state clears immediately. A pending `bus_ready` is not issued. After deassertion the block waits for a new `bus_valid` rising.

## Test plan
- Averaging: enable, AVG_LOG2 = 2. Y = 10, 11, 12, 13 and Z = −1, −2, −2, −2 → count = 1; LATEST = 0x8000_0BFE; `display_word` = 0x000B_00FE; DATA read = 0x8000_0BFE, then count = 0.
- Empty read: DATA read with count = 0 → `bus_rdata` = 0x0000_0000; STATUS = 0x0001_0000; pointers unchanged.
- Overflow: DEPTH = 16, push 17 blocks with no reads → count = 16, STATUS bit17 = 1 and bit18 = 1; first DATA read returns entry #1. CTRL write 0x5 clears overflow.
- Simultaneous push/pop: with count = 16, a final `sample_valid` on the same edge as a DATA acceptance → count stays 16, no overflow, entry stored.
- IRQ and flush: threshold = 3, push 3 blocks → `irq` = 1 one cycle after the third push. CTRL write 0x0301 (flush) → count = 0 and `irq` = 0 next cycle; LATEST bit31 = 0.
- Reset mid-operation: assert `reset` after 2 of 4 samples and during a pending read → `bus_ready` = 0 and all outputs 0 immediately. After release, 4 new samples produce exactly one entry.
